hex_display_scheduler: RTL

Time-shares a single combinational hex-to-7-segment decoder between NUM_DIGITS display digits. Client logic writes 4-bit digit values through a valid/ready port. A round-robin scheduler re-decodes only the digits that changed and latches each result into a per-digit segment register that drives the board's HEX outputs. It sits between lab datapaths (counters, ALUs, register files) and the HEX0–HEXn pins.

---
 rtl/hex_display_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
// Time-shares one combinational hex-to-7-segment decoder across NUM_DIGITS
// display digits. Clients write 4-bit digit values over a valid/ready port.
// A round-robin scheduler re-decodes only the digits marked dirty and latches
// the result into a per-digit active-low segment register.
// Optional feature macro: HEX_SCHED_BLANK_EN adds the wr_blank port and a
// per-digit blank bit that forces a digit dark when it is next captured.
module hex_display_scheduler #(
   parameter int NUM_DIGITS = 6,
   parameter int PTR_W      = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [PTR_W-1:0]        wr_addr,
   input  logic [3:0]              wr_data,
`ifdef HEX_SCHED_BLANK_EN
   input  logic                    wr_blank,
`endif
   output logic [7*NUM_DIGITS-1:0] seg_out,
   output logic                    seg_valid,
   output logic [PTR_W-1:0]        seg_addr
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CAPTURE
   } state_t;

   state_t                state;
   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      ptr_next;
   logic [3:0]            value [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dirty;
   logic [6:0]            seg [NUM_DIGITS];
   logic [3:0]            dec_in;
   logic [6:0]            dec_out;
   logic                  wr_take;
   logic [6:0]            capture_seg;
`ifdef HEX_SCHED_BLANK_EN
   logic [NUM_DIGITS-1:0] blank;
`endif

   // Writes are refused only while a capture is in flight, so a client never
   // has to look at its own request to know whether it may proceed.
   assign wr_ready = (state != CAPTURE);

   // Out-of-range addresses are still handshaken but must not touch any digit.
   assign wr_take = wr_valid && wr_ready && (32'(wr_addr) < 32'(NUM_DIGITS));

   // Next round-robin slot; wraps after the last digit (a no-op for one digit).
   always_comb begin
      ptr_next = ptr + 1'b1;
      if (ptr == PTR_W'(NUM_DIGITS - 1)) begin
         ptr_next = '0;
      end
   end

   // The single shared decoder, driven from the registered nibble dec_in.
   always_comb begin
      dec_out = 7'h7F;
      case (dec_in)
         4'h0: dec_out = 7'h40;
         4'h1: dec_out = 7'h79;
         4'h2: dec_out = 7'h24;
         4'h3: dec_out = 7'h30;
         4'h4: dec_out = 7'h19;
         4'h5: dec_out = 7'h12;
         4'h6: dec_out = 7'h02;
         4'h7: dec_out = 7'h78;
         4'h8: dec_out = 7'h00;
         4'h9: dec_out = 7'h10;
         4'hA: dec_out = 7'h08;
         4'hB: dec_out = 7'h03;
         4'hC: dec_out = 7'h46;
         4'hD: dec_out = 7'h21;
         4'hE: dec_out = 7'h06;
         4'hF: dec_out = 7'h0E;
         default: dec_out = 7'h7F;
      endcase
   end

   // Pick what the current digit stores on capture: dark if blanked, else decoded.
   always_comb begin
      capture_seg = dec_out;
`ifdef HEX_SCHED_BLANK_EN
      if (blank[ptr]) begin
         capture_seg = 7'h7F;
      end
`endif
   end

   // Scheduler FSM plus the per-digit storage it manages; client writes are
   // applied after the FSM actions so a set of dirty beats a same-edge clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         dec_in    <= '0;
         dirty     <= '1;
         seg_valid <= 1'b0;
         seg_addr  <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            value[i] <= 4'h0;
            seg[i]   <= 7'h7F;
         end
`ifdef HEX_SCHED_BLANK_EN
         blank <= '0;
`endif
      end else begin
         seg_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (dirty[ptr]) begin
                  state <= LOAD;
               end else begin
                  ptr <= ptr_next;
               end
            end
            LOAD: begin
               dec_in     <= value[ptr];
               dirty[ptr] <= 1'b0;
               state      <= CAPTURE;
            end
            CAPTURE: begin
               seg[ptr]  <= capture_seg;
               seg_valid <= 1'b1;
               seg_addr  <= ptr;
               ptr       <= ptr_next;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         if (wr_take) begin
            value[wr_addr] <= wr_data;
            dirty[wr_addr] <= 1'b1;
`ifdef HEX_SCHED_BLANK_EN
            blank[wr_addr] <= wr_blank;
`endif
         end
      end
   end

   // Flatten the per-digit segment registers onto the board-facing bus.
   always_comb begin
      seg_out = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         seg_out[7*i +: 7] = seg[i];
      end
   end

endmodule
